// File: rtl/param_delay_line.sv
// param_delay_line: WIDTH-bit data plus a valid bit, delayed by DEPTH
// clock-enabled register stages. Supports stall (CE), a synchronous flush
// that kills every in-flight valid, and a live count of valid tokens held.
module param_delay_line #(
  parameter int unsigned      WIDTH = 1,
  parameter int unsigned      DEPTH = 1,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                       CLK,
  input  logic                       ASYNCRESET,
  input  logic [WIDTH-1:0]           I,
  input  logic                       valid_in,
  input  logic                       CE,
  input  logic                       flush,
  output logic [WIDTH-1:0]           O,
  output logic                       valid_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;
  logic             w_last_valid;

  assign w_last_valid = r_valid[DEPTH-1];

  // Stage 0 data: captures I on every enabled edge; data is never gated by valid.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_data[0] <= INIT;
    end else if (CE) begin
      r_data[0] <= I;
    end
  end

  // Stage 0 valid: flush wins over the token presented in the same cycle.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_valid[0] <= 1'b0;
    end else if (flush) begin
      r_valid[0] <= 1'b0;
    end else if (CE) begin
      r_valid[0] <= valid_in;
    end
  end

  // Stages 1..DEPTH-1 shift from the previous stage; empty when DEPTH == 1.
  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
    // Data of stage gi follows stage gi-1 on enabled edges, flush or not.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
        r_data[gi] <= INIT;
      end else if (CE) begin
        r_data[gi] <= r_data[gi-1];
      end
    end

    // Valid of stage gi shifts on enabled edges and is cleared by flush.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
        r_valid[gi] <= 1'b0;
      end else if (flush) begin
        r_valid[gi] <= 1'b0;
      end else if (CE) begin
        r_valid[gi] <= r_valid[gi-1];
      end
    end
  end

  // Occupancy: one token enters and/or one leaves per enabled edge, so the
  // count moves by at most one and stays equal to the number of set valids.
  always_comb begin
    w_count_next = r_count;
    if (flush) begin
      w_count_next = '0;
    end else if (CE) begin
      if (valid_in && !w_last_valid) begin
        w_count_next = r_count + CW'(1);
      end else if (!valid_in && w_last_valid) begin
        w_count_next = r_count - CW'(1);
      end
    end
  end

  // Occupancy register.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign O         = r_data[DEPTH-1];
  assign valid_out = w_last_valid;
  assign count     = r_count;

`ifndef SYNTHESIS
  // Bit k set: a token was accepted k+1 edges ago and every edge since then
  // was enabled without flush, so it must now sit k stages down the line.
  logic [DEPTH-1:0] r_chk_tok;

  // Tracks tokens launched under uninterrupted enable for the latency check.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_chk_tok <= '0;
    end else if (CE && !flush) begin
      r_chk_tok <= (r_chk_tok << 1) | DEPTH'(valid_in);
    end else begin
      r_chk_tok <= '0;
    end
  end

  a_latency : assert property (@(posedge CLK) disable iff (ASYNCRESET)
    r_chk_tok[DEPTH-1] |-> valid_out);

  a_count_max : assert property (@(posedge CLK) disable iff (ASYNCRESET)
    32'(r_count) <= DEPTH);

  a_count_pop : assert property (@(posedge CLK) disable iff (ASYNCRESET)
    32'(r_count) == $countones(r_valid));

  a_flush : assert property (@(posedge CLK) disable iff (ASYNCRESET)
    flush |=> !valid_out);
`endif

endmodule

// File: tb/tb_param_delay_line.sv
// Directed self-checking bench for param_delay_line (WIDTH=8, DEPTH=3, INIT=8'hA5).
module tb_param_delay_line;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       vin;
  logic       ce;
  logic       flush;
  logic [7:0] dout;
  logic       vout;
  logic [1:0] cnt;

  int n_tests;
  int n_fail;

  param_delay_line #(
    .WIDTH (8),
    .DEPTH (3),
    .INIT  (8'hA5)
  ) dut (
    .CLK        (clk),
    .ASYNCRESET (rst),
    .I          (din),
    .valid_in   (vin),
    .CE         (ce),
    .flush      (flush),
    .O          (dout),
    .valid_out  (vout),
    .count      (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across one edge with idle inputs, then release.
  task automatic do_reset();
    rst = 1'b1; ce = 1'b1; flush = 1'b0; vin = 1'b0; din = 8'h00;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; ce = 1'b0; flush = 1'b0; vin = 1'b0; din = 8'h00;
    #2;
    rst = 1'b1;  // no clock edge before time 5
    #1;
    n_tests++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL reset_o got=%h exp=a5", dout); end
    n_tests++; if (vout !== 1'b0)  begin n_fail++; $display("FAIL reset_v got=%b exp=0", vout); end
    n_tests++; if (cnt !== 2'd0)   begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    $display("[TB] reset async O=%h v=%b cnt=%0d", dout, vout, cnt);
    ce = 1'b1; vin = 1'b1; din = 8'h3C;
    step();
    n_tests++; if (dout !== 8'hA5 || vout !== 1'b0 || cnt !== 2'd0) begin
      n_fail++; $display("FAIL reset_held got O=%h v=%b cnt=%0d exp O=a5 v=0 cnt=0", dout, vout, cnt);
    end
    $display("[TB] reset held O=%h v=%b cnt=%0d", dout, vout, cnt);
    vin = 1'b0; din = 8'h00;
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    logic [7:0] in_d  [7] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00};
    logic       in_v  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] exp_o [7] = '{8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    logic       exp_v [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] exp_c [7] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      ce = 1'b1; flush = 1'b0; din = in_d[i]; vin = in_v[i];
      step();
      n_tests++; if (dout !== exp_o[i]) begin n_fail++; $display("FAIL stream_o e%0d got=%h exp=%h", i + 1, dout, exp_o[i]); end
      n_tests++; if (vout !== exp_v[i]) begin n_fail++; $display("FAIL stream_v e%0d got=%b exp=%b", i + 1, vout, exp_v[i]); end
      n_tests++; if (cnt !== exp_c[i])  begin n_fail++; $display("FAIL stream_cnt e%0d got=%0d exp=%0d", i + 1, cnt, exp_c[i]); end
      $display("[TB] stream e%0d I=%h vi=%b -> O=%h v=%b cnt=%0d", i + 1, in_d[i], in_v[i], dout, vout, cnt);
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp_o [3] = '{8'h11, 8'h22, 8'h00};
    logic       exp_v [3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0] exp_c [3] = '{2'd2, 2'd1, 2'd0};
    do_reset();
    ce = 1'b1; flush = 1'b0; vin = 1'b1; din = 8'h11; step();
    din = 8'h22; step();
    for (int i = 0; i < 5; i++) begin
      ce = 1'b0; vin = 1'b1; din = 8'hFF;
      step();
      n_tests++; if (dout !== 8'hA5 || vout !== 1'b0 || cnt !== 2'd2) begin
        n_fail++; $display("FAIL stall_frozen c%0d got O=%h v=%b cnt=%0d exp O=a5 v=0 cnt=2", i, dout, vout, cnt);
      end
      $display("[TB] stall c%0d O=%h v=%b cnt=%0d", i, dout, vout, cnt);
    end
    for (int i = 0; i < 3; i++) begin
      ce = 1'b1; vin = 1'b0; din = 8'h00;
      step();
      n_tests++; if (dout !== exp_o[i] || vout !== exp_v[i] || cnt !== exp_c[i]) begin
        n_fail++; $display("FAIL stall_resume e%0d got O=%h v=%b cnt=%0d exp O=%h v=%b cnt=%0d",
                           i, dout, vout, cnt, exp_o[i], exp_v[i], exp_c[i]);
      end
      $display("[TB] resume e%0d O=%h v=%b cnt=%0d", i, dout, vout, cnt);
    end
  endtask

  task automatic test_flush();
    logic [7:0] exp_o [3] = '{8'h03, 8'h77, 8'h00};
    do_reset();
    ce = 1'b1; flush = 1'b0; vin = 1'b1;
    din = 8'h01; step();
    din = 8'h02; step();
    din = 8'h03; step();
    n_tests++; if (cnt !== 2'd3 || vout !== 1'b1 || dout !== 8'h01) begin
      n_fail++; $display("FAIL flush_pre got O=%h v=%b cnt=%0d exp O=01 v=1 cnt=3", dout, vout, cnt);
    end
    flush = 1'b1; ce = 1'b1; vin = 1'b1; din = 8'h77;
    step();
    n_tests++; if (cnt !== 2'd0) begin n_fail++; $display("FAIL flush_cnt got=%0d exp=0", cnt); end
    n_tests++; if (vout !== 1'b0) begin n_fail++; $display("FAIL flush_v got=%b exp=0", vout); end
    n_tests++; if (dout !== 8'h02) begin n_fail++; $display("FAIL flush_shift got=%h exp=02", dout); end
    $display("[TB] flush ce=1 O=%h v=%b cnt=%0d", dout, vout, cnt);
    for (int i = 0; i < 3; i++) begin
      flush = 1'b0; vin = 1'b0; din = 8'h00;
      step();
      n_tests++; if (vout !== 1'b0 || cnt !== 2'd0 || dout !== exp_o[i]) begin
        n_fail++; $display("FAIL flush_after e%0d got O=%h v=%b cnt=%0d exp O=%h v=0 cnt=0", i, dout, vout, cnt, exp_o[i]);
      end
      $display("[TB] post-flush e%0d O=%h v=%b cnt=%0d", i, dout, vout, cnt);
    end
    // Flush while stalled: valids cleared, data held.
    vin = 1'b1; din = 8'h09; step();
    ce = 1'b0; flush = 1'b1; vin = 1'b1; din = 8'hAA; step();
    n_tests++; if (cnt !== 2'd0 || vout !== 1'b0 || dout !== 8'h00) begin
      n_fail++; $display("FAIL flush_ce0 got O=%h v=%b cnt=%0d exp O=00 v=0 cnt=0", dout, vout, cnt);
    end
    $display("[TB] flush ce=0 O=%h v=%b cnt=%0d", dout, vout, cnt);
    ce = 1'b1; flush = 1'b0; vin = 1'b0; din = 8'h00;
    step(); step();
    n_tests++; if (dout !== 8'h09 || vout !== 1'b0 || cnt !== 2'd0) begin
      n_fail++; $display("FAIL flush_ce0_hold got O=%h v=%b cnt=%0d exp O=09 v=0 cnt=0", dout, vout, cnt);
    end
    $display("[TB] flush ce=0 drain O=%h v=%b cnt=%0d", dout, vout, cnt);
  endtask

  task automatic test_bubbles();
    logic [7:0] in_d  [8] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h00, 8'h00, 8'h00};
    logic       in_v  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] exp_o [8] = '{8'hA5, 8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h00};
    logic       exp_v [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] exp_c [8] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ce = 1'b1; flush = 1'b0; din = in_d[i]; vin = in_v[i];
      step();
      n_tests++; if (dout !== exp_o[i] || vout !== exp_v[i] || cnt !== exp_c[i]) begin
        n_fail++; $display("FAIL bubble e%0d got O=%h v=%b cnt=%0d exp O=%h v=%b cnt=%0d",
                           i + 1, dout, vout, cnt, exp_o[i], exp_v[i], exp_c[i]);
      end
      $display("[TB] bubble e%0d vi=%b -> O=%h v=%b cnt=%0d", i + 1, in_v[i], dout, vout, cnt);
    end
  endtask

  task automatic test_reset_midstream();
    logic       exp_v [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] exp_o [3] = '{8'hA5, 8'hA5, 8'hC3};
    do_reset();
    ce = 1'b1; flush = 1'b0; vin = 1'b1;
    din = 8'h05; step();
    din = 8'h06; step();
    n_tests++; if (cnt !== 2'd2) begin n_fail++; $display("FAIL midrst_pre got cnt=%0d exp=2", cnt); end
    rst = 1'b1;
    #1;
    n_tests++; if (dout !== 8'hA5 || vout !== 1'b0 || cnt !== 2'd0) begin
      n_fail++; $display("FAIL midrst_async got O=%h v=%b cnt=%0d exp O=a5 v=0 cnt=0", dout, vout, cnt);
    end
    $display("[TB] midstream reset O=%h v=%b cnt=%0d", dout, vout, cnt);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vin = (i == 0); din = (i == 0) ? 8'hC3 : 8'h00;
      step();
      n_tests++; if (vout !== exp_v[i] || dout !== exp_o[i] || cnt !== 2'd1) begin
        n_fail++; $display("FAIL midrst_after e%0d got O=%h v=%b cnt=%0d exp O=%h v=%b cnt=1",
                           i + 1, dout, vout, cnt, exp_o[i], exp_v[i]);
      end
      $display("[TB] post-reset e%0d O=%h v=%b cnt=%0d", i + 1, dout, vout, cnt);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_bubbles();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
